cc_gen: RTL and testbench
=========================

Name: cc_gen

Overview:
- Producer side of the branch-enable path: generates and holds the N/Z/P condition codes that the branch-enable logic consumes.
- Sits on the datapath bus:
  - samples the 16-bit bus on LD.CC;
  - restores CC and privilege from the PSR image on ld_psr (RTI);
  - keeps a small shadow stack of {priv, N, Z, P} for interrupt entry and exit.
- Outputs feed the branch-enable logic and the PSR read path.

Parameters:
- WIDTH, 16, datapath/bus width; MSB is the sign bit.
- STACK_DEPTH, 4, number of shadow CC/priv entries; power of two, 2..16.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- bus_in  in  WIDTH  datapath bus value to classify.
- ld_cc  in  1  load N/Z/P from bus_in.
- ld_psr  in  1  load priv/N/Z/P from psr_in.
- psr_in  in  WIDTH  PSR image; bit15=priv (1=user), bits2:0=N,Z,P.
- push_cc  in  1  push current {priv,N,Z,P} onto shadow stack (interrupt entry).
- pop_cc  in  1  pop top entry into priv/N/Z/P (interrupt exit).
- set_super  in  1  force priv=0 (supervisor).
- clr_err  in  1  clear sticky stack_err.
- n, z, p  out  1 each  registered condition codes.
- priv  out  1  registered privilege bit.
- psr_out  out  WIDTH  {priv, 12'b0, n, z, p}; combinational from registers.
- stack_full  out  1  stack holds STACK_DEPTH entries.
- stack_empty  out  1  stack holds zero entries.
- stack_err  out  1  sticky overflow/underflow flag.

Behaviour:
- Reset (rst_n low, asynchronous):
  - n=0, z=1, p=0, priv=0.
  - Stack pointer=0, so stack_empty=1, stack_full=0.
  - stack_err=0.
  - Stack contents are don't-care.
- Classification (ld_cc): N=bus_in[WIDTH-1]; Z=(bus_in==0); P=!N&&!Z.
  - Exactly one of n/z/p is high after any ld_cc.
  - One-cycle latency: visible the cycle after the ld_cc edge.
- ld_psr: priv<=psr_in[15]; {n,z,p}<=psr_in[2:0]; loaded verbatim, no one-hot check.
- Priority for the CC/priv registers each cycle: pop_cc (if not empty) > ld_psr > ld_cc > hold.
- set_super:
  - Applies to priv after the above.
  - Wins over pop/ld_psr for priv only; n/z/p are unaffected.
- Stack:
  - Push writes the pre-edge {priv,n,z,p} to entry[sp]; sp<=sp+1.
  - Pop restores entry[sp-1]; sp<=sp-1.
  - push_cc and pop_cc in the same cycle: a pop is performed if not empty. The pushed value is discarded. stack_err<=1.
  - Push when full: no write, sp unchanged, stack_err<=1; CC registers follow the other loads.
  - Pop when empty: registers follow ld_psr/ld_cc/hold, sp unchanged, stack_err<=1.
  - Push combined with ld_cc in the same cycle: the old value is pushed and the new value is loaded.
- stack_err:
  - Remains set until clr_err or reset.
  - If clr_err and a new error occur in the same cycle, the error wins (err stays 1).
- Reset asserted mid-operation aborts all pending loads; stack is emptied.

Optional Feature:
- Macro: CC_STACK_EN.
- Defined: shadow stack as above.
- Undefined:
  - No stack storage.
  - push_cc and pop_cc are ignored.
  - stack_full=0, stack_empty=1, stack_err=0 constant.
  - clr_err is ignored.
  - All other behaviour is unchanged.

Decomposition:
- Shared package (cc_pkg):
  - PSR bit-position constants PSR_PRIV=15, PSR_N=2, PSR_Z=1, PSR_P=0.
  - A packed cc_t struct {priv,n,z,p}.
  - The reset value constant CC_RESET.
- Sub-module: cc_shadow_stack, a LIFO of cc_t with push/pop/full/empty/err. It is instantiated only under CC_STACK_EN.
- Classification stays inline in cc_gen.

Test Plan:
- Reset, then ld_cc with bus_in=16'h8000, 16'h0000, 16'h0001, 16'h7FFF on successive cycles -> nzp reads 100, 010, 001, 001, each one cycle after its load.
- ld_psr with psr_in=16'h8004 -> priv=1, nzp=100, psr_out=16'h8004. Same cycle as ld_cc with bus=0 -> ld_psr wins.
- Interrupt sequence:
  - State nzp=001/priv=1: push_cc + set_super -> priv=0.
  - ld_cc with bus=0 -> nzp=010.
  - pop_cc -> nzp=001, priv=1, stack_empty=1.
- Push 4 times -> stack_full=1. 5th push -> stack_err=1 and sp unchanged. Pop 4 entries -> LIFO order. 5th pop -> registers held, err still 1. clr_err -> err=0.
- rst_n asserted low asynchronously mid-cycle with 2 entries stacked -> n=0, z=1, p=0, priv=0, stack_empty=1 immediately, without waiting for a clk edge.
- Build without CC_STACK_EN: push_cc/pop_cc toggled -> CC unchanged, stack_empty=1, stack_err=0.

Source files
------------

// File: rtl/cc_pkg.sv
// Shared definitions for the condition-code generator.
// Contents: PSR bit positions, the packed cc_t {priv,n,z,p} record,
// and the reset value CC_RESET (supervisor, Z set).
package cc_pkg;

  localparam int PSR_PRIV = 15;
  localparam int PSR_N    = 2;
  localparam int PSR_Z    = 1;
  localparam int PSR_P    = 0;

  typedef struct packed {
    logic priv;
    logic n;
    logic z;
    logic p;
  } cc_t;

  // priv=0 (supervisor), nzp=010
  localparam cc_t CC_RESET = cc_t'(4'b0010);

endpackage

// File: rtl/cc_shadow_stack.sv
// LIFO of cc_t snapshots used on interrupt entry/exit.
// Ports:
//   clk, rst_n      clock, async active-low reset (empties the stack)
//   push, pop       requests; pop has priority, push+pop is an error
//   clr_err         clears the sticky error (a same-cycle error wins)
//   din             value pushed (pre-edge CC/priv)
//   dout            top-of-stack entry, valid when !empty
//   pop_ok          a pop is actually performed this cycle
//   full, empty     occupancy flags
//   err             sticky overflow/underflow/collision flag
import cc_pkg::*;

module cc_shadow_stack #(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  logic pop,
  input  logic clr_err,
  input  cc_t  din,
  output cc_t  dout,
  output logic pop_ok,
  output logic full,
  output logic empty,
  output logic err
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] SP_FULL = (AW+1)'(DEPTH);

  // sp is one bit wider than the index so full and empty are distinct.
  logic [AW:0] sp;
  logic [AW:0] sp_m1;
  cc_t         mem [DEPTH];
  logic        do_push;
  logic        err_ev;

  assign full    = (sp == SP_FULL);
  assign empty   = (sp == '0);
  assign sp_m1   = sp - 1'b1;
  assign dout    = mem[sp_m1[AW-1:0]];

  assign pop_ok  = pop && !empty;
  // A simultaneous push is dropped in favour of the pop.
  assign do_push = push && !pop && !full;
  assign err_ev  = (push && pop) || (push && full) || (pop && empty);

  // Storage is don't-care after reset, so it carries no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[sp[AW-1:0]] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp  <= '0;
      err <= 1'b0;
    end else begin
      if (pop_ok)       sp <= sp - 1'b1;
      else if (do_push) sp <= sp + 1'b1;
      if (err_ev)       err <= 1'b1;
      else if (clr_err) err <= 1'b0;
    end
  end

endmodule

// File: rtl/cc_gen.sv
// Condition-code generator: holds N/Z/P and the privilege bit for the
// branch-enable logic and the PSR read path.
// Optional feature macro: CC_STACK_EN (shadow stack for interrupt
// entry/exit). Without it push_cc/pop_cc/clr_err are ignored and the
// stack flags are constant (full=0, empty=1, err=0).
// Ports:
//   clk, rst_n        clock, async active-low reset
//   bus_in            datapath bus value classified on ld_cc
//   ld_cc             load N/Z/P from bus_in
//   ld_psr, psr_in    load priv/N/Z/P verbatim from the PSR image
//   push_cc, pop_cc   shadow stack push / pop
//   set_super         force priv=0 (overrides every other priv source)
//   clr_err           clear sticky stack_err
//   n, z, p, priv     registered condition codes and privilege
//   psr_out           {priv, zeros, n, z, p}
//   stack_full/empty/err  shadow stack status
import cc_pkg::*;

module cc_gen #(
  parameter int WIDTH       = 16,
  parameter int STACK_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] bus_in,
  input  logic             ld_cc,
  input  logic             ld_psr,
  input  logic [WIDTH-1:0] psr_in,
  input  logic             push_cc,
  input  logic             pop_cc,
  input  logic             set_super,
  input  logic             clr_err,
  output logic             n,
  output logic             z,
  output logic             p,
  output logic             priv,
  output logic [WIDTH-1:0] psr_out,
  output logic             stack_full,
  output logic             stack_empty,
  output logic             stack_err
);

  cc_t  cc, cc_nxt, stk_top;
  logic pop_ok;
  logic cls_n, cls_z, cls_p;

  assign cls_n = bus_in[WIDTH-1];
  assign cls_z = (bus_in == '0);
  assign cls_p = !cls_n && !cls_z;

`ifdef CC_STACK_EN
  cc_shadow_stack #(.DEPTH(STACK_DEPTH)) u_stack (
    .clk    (clk),
    .rst_n  (rst_n),
    .push   (push_cc),
    .pop    (pop_cc),
    .clr_err(clr_err),
    .din    (cc),
    .dout   (stk_top),
    .pop_ok (pop_ok),
    .full   (stack_full),
    .empty  (stack_empty),
    .err    (stack_err)
  );
`else
  logic unused_stack;
  assign unused_stack = ^{push_cc, pop_cc, clr_err};
  assign pop_ok      = 1'b0;
  assign stk_top     = CC_RESET;
  assign stack_full  = 1'b0;
  assign stack_empty = 1'b1;
  assign stack_err   = 1'b0;
`endif

  // Middle PSR bits carry nothing for this block.
  logic unused_psr;
  assign unused_psr = ^psr_in[PSR_PRIV-1:PSR_N+1];

  // pop > ld_psr > ld_cc > hold; set_super then overrides priv alone.
  always_comb begin
    cc_nxt = cc;
    if (pop_ok) begin
      cc_nxt = stk_top;
    end else if (ld_psr) begin
      cc_nxt.priv = psr_in[PSR_PRIV];
      cc_nxt.n    = psr_in[PSR_N];
      cc_nxt.z    = psr_in[PSR_Z];
      cc_nxt.p    = psr_in[PSR_P];
    end else if (ld_cc) begin
      cc_nxt.n = cls_n;
      cc_nxt.z = cls_z;
      cc_nxt.p = cls_p;
    end
    if (set_super) cc_nxt.priv = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cc <= CC_RESET;
    else        cc <= cc_nxt;
  end

  assign n    = cc.n;
  assign z    = cc.z;
  assign p    = cc.p;
  assign priv = cc.priv;

  always_comb begin
    psr_out           = '0;
    psr_out[PSR_PRIV] = cc.priv;
    psr_out[PSR_N]    = cc.n;
    psr_out[PSR_Z]    = cc.z;
    psr_out[PSR_P]    = cc.p;
  end

endmodule

// File: tb/tb_cc_gen.sv
// Scoreboard bench for cc_gen: stimulus queues the expected output
// vector after each edge; a monitor on the falling edge pops and compares.
module tb_cc_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] bus_in, psr_in, psr_out;
  logic        ld_cc, ld_psr, push_cc, pop_cc, set_super, clr_err;
  logic        n, z, p, priv, stack_full, stack_empty, stack_err;

  typedef struct {
    string       nm;
    logic [22:0] v;
  } exp_t;

  exp_t q[$];
  int   n_vec  = 0;
  int   n_fail = 0;

  cc_gen #(.WIDTH(16), .STACK_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .bus_in(bus_in), .ld_cc(ld_cc),
    .ld_psr(ld_psr), .psr_in(psr_in), .push_cc(push_cc), .pop_cc(pop_cc),
    .set_super(set_super), .clr_err(clr_err), .n(n), .z(z), .p(p),
    .priv(priv), .psr_out(psr_out), .stack_full(stack_full),
    .stack_empty(stack_empty), .stack_err(stack_err)
  );

  always #5 clk = ~clk;

  // Packed vector: {priv, nzp, full, empty, err, psr_out}
  function automatic logic [22:0] ev(input bit pr, input bit [2:0] nzp,
                                     input bit fu, input bit em, input bit er);
    return {pr, nzp, fu, em, er, pr, 12'b0, nzp};
  endfunction

  // Monitor
  always @(negedge clk) begin
    logic [22:0] act;
    exp_t        e;
    while (q.size() > 0) begin
      e   = q.pop_front();
      act = {priv, n, z, p, stack_full, stack_empty, stack_err, psr_out};
      n_vec++;
      if (act !== e.v) begin
        n_fail++;
        $display("FAIL %s: got %h expected %h", e.nm, act, e.v);
      end
    end
  end

  task automatic clr_ctl();
    ld_cc = 0; ld_psr = 0; push_cc = 0; pop_cc = 0; set_super = 0; clr_err = 0;
  endtask

  task automatic step(input string nm, input logic [22:0] e);
    @(posedge clk); #1;
    q.push_back('{nm, e});
    clr_ctl();
  endtask

  initial begin
    rst_n = 0; bus_in = '0; psr_in = '0; clr_ctl();
    #1 q.push_back('{"reset", ev(0, 3'b010, 0, 1, 0)});
    @(posedge clk); @(posedge clk); #1 rst_n = 1;

    ld_cc = 1; bus_in = 16'h8000; step("cls_8000", ev(0, 3'b100, 0, 1, 0));
    ld_cc = 1; bus_in = 16'h0000; step("cls_0000", ev(0, 3'b010, 0, 1, 0));
    ld_cc = 1; bus_in = 16'h0001; step("cls_0001", ev(0, 3'b001, 0, 1, 0));
    ld_cc = 1; bus_in = 16'h7FFF; step("cls_7fff", ev(0, 3'b001, 0, 1, 0));
    ld_psr = 1; psr_in = 16'h8004; step("ld_psr", ev(1, 3'b100, 0, 1, 0));
    ld_psr = 1; psr_in = 16'h8001; ld_cc = 1; bus_in = 16'h0000;
    step("psr_over_cc", ev(1, 3'b001, 0, 1, 0));

`ifdef CC_STACK_EN
    push_cc = 1; set_super = 1; step("int_entry", ev(0, 3'b001, 0, 0, 0));
    ld_cc = 1; bus_in = 16'h0000; step("isr_ldcc", ev(0, 3'b010, 0, 0, 0));
    pop_cc = 1; step("int_exit", ev(1, 3'b001, 0, 1, 0));

    // Fill with distinct snapshots; each push saves the pre-edge value.
    push_cc = 1; ld_psr = 1; psr_in = 16'h0004; step("push1", ev(0, 3'b100, 0, 0, 0));
    push_cc = 1; ld_psr = 1; psr_in = 16'h8002; step("push2", ev(1, 3'b010, 0, 0, 0));
    push_cc = 1; ld_psr = 1; psr_in = 16'h0001; step("push3", ev(0, 3'b001, 0, 0, 0));
    push_cc = 1; ld_psr = 1; psr_in = 16'h8006; step("push4_full", ev(1, 3'b110, 1, 0, 0));
    push_cc = 1; ld_cc = 1; bus_in = 16'h0000; step("push5_ovf", ev(1, 3'b010, 1, 0, 1));
    pop_cc = 1; step("pop1", ev(0, 3'b001, 0, 0, 1));
    pop_cc = 1; step("pop2", ev(1, 3'b010, 0, 0, 1));
    pop_cc = 1; step("pop3", ev(0, 3'b100, 0, 0, 1));
    pop_cc = 1; step("pop4", ev(1, 3'b001, 0, 1, 1));
    pop_cc = 1; step("pop5_udf", ev(1, 3'b001, 0, 1, 1));
    clr_err = 1; step("clr_err", ev(1, 3'b001, 0, 1, 0));

    push_cc = 1; step("push_one", ev(1, 3'b001, 0, 0, 0));
    push_cc = 1; pop_cc = 1; ld_cc = 1; bus_in = 16'h8000;
    step("push_pop", ev(1, 3'b001, 0, 1, 1));
    clr_err = 1; pop_cc = 1; step("clr_vs_err", ev(1, 3'b001, 0, 1, 1));
    clr_err = 1; step("clr_err2", ev(1, 3'b001, 0, 1, 0));

    ld_psr = 1; psr_in = 16'h8001; step("pre_rst", ev(1, 3'b001, 0, 1, 0));
    push_cc = 1; step("pre_rst_p1", ev(1, 3'b001, 0, 0, 0));
    push_cc = 1; step("pre_rst_p2", ev(1, 3'b001, 0, 0, 0));
`else
    set_super = 1; push_cc = 1; step("int_entry", ev(0, 3'b001, 0, 1, 0));
    ld_cc = 1; bus_in = 16'h0000; step("isr_ldcc", ev(0, 3'b010, 0, 1, 0));
    pop_cc = 1; step("pop_ignored", ev(0, 3'b010, 0, 1, 0));
    push_cc = 1; step("push_ignored", ev(0, 3'b010, 0, 1, 0));
    push_cc = 1; pop_cc = 1; clr_err = 1; step("both_ignored", ev(0, 3'b010, 0, 1, 0));
    pop_cc = 1; ld_cc = 1; bus_in = 16'h8000; step("pop_vs_ldcc", ev(0, 3'b100, 0, 1, 0));
    ld_psr = 1; psr_in = 16'h8001; step("pre_rst", ev(1, 3'b001, 0, 1, 0));
`endif

    // Asynchronous reset mid-cycle; the falling-edge check lands before
    // any rising edge, and a pending load is dropped.
    @(posedge clk); #2;
    ld_cc = 1; bus_in = 16'h8000;
    rst_n = 0;
    #1 q.push_back('{"async_rst", ev(0, 3'b010, 0, 1, 0)});
    step("rst_hold", ev(0, 3'b010, 0, 1, 0));
    rst_n = 1;
    ld_cc = 1; bus_in = 16'h0005; step("post_rst", ev(0, 3'b001, 0, 1, 0));

    repeat (3) @(posedge clk);
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d left, expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
